// File: rtl/dcache_write_buffer_pkg.sv
// Shared types for the dcache write buffer: write-type encodings, line width
// and the buffered entry record.
package dcache_write_buffer_pkg;

   localparam int WB_LINE_W = 256;

   typedef enum logic [2:0] {
      BYTE = 3'b000,
      HALF = 3'b001,
      WORD = 3'b010,
      LINE = 3'b100
   } wr_type_e;

   typedef struct packed {
      wr_type_e                wr_type;
      logic [31:0]             addr;
      logic [3:0]              wstrb;
      logic [WB_LINE_W-1:0]    data;
   } wb_entry_t;

   // Two addresses fall in the same 32-byte line.
   function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
      return a[31:5] == b[31:5];
   endfunction

endpackage

// File: rtl/dcache_write_buffer_wb_fifo.sv
// Circular entry store for the write buffer: head/tail pointers, occupancy
// count and per-entry valid bits, with every entry address exposed for hits.
module wb_fifo
   import dcache_write_buffer_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  wb_entry_t                push_entry,
   input  logic                     pop,
   output wb_entry_t                head_entry,
   output logic [CNT_W-1:0]         count,
   output logic [DEPTH-1:0]         entry_valid,
   output logic [DEPTH-1:0][31:0]   entry_addr
);

   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   wb_entry_t        mem_q [DEPTH];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;
      // Pointers are power-of-two wide, so the increment wraps modulo DEPTH.
      if (pop) begin
         head_d          = head_q + AW'(1);
         valid_d[head_q] = 1'b0;
      end
      if (push) begin
         tail_d          = tail_q + AW'(1);
         valid_d[tail_q] = 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // NOTE: entry storage is deliberately not reset; valid bits and count
   // already mark stale contents as unused.
   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= push_entry;
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem_q[i].addr;
   end

   assign head_entry  = mem_q[head_q];
   assign count       = count_q;
   assign entry_valid = valid_q;

endmodule

// File: rtl/dcache_write_buffer.sv
// Dcache write buffer: queues writes toward the AXI bridge in order and holds
// back any read whose line is still pending in the buffer.
module dcache_write_buffer
   import dcache_write_buffer_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int LINE_W = WB_LINE_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_wr_req,
   input  logic [2:0]        in_wr_type,
   input  logic [31:0]       in_wr_addr,
   input  logic [3:0]        in_wr_wstrb,
   input  logic [LINE_W-1:0] in_wr_data,
   output logic              in_wr_rdy,
   input  logic              in_rd_req,
   input  logic [2:0]        in_rd_type,
   input  logic [31:0]       in_rd_addr,
   output logic              in_rd_rdy,
   output logic              out_wr_req,
   output logic [2:0]        out_wr_type,
   output logic [31:0]       out_wr_addr,
   output logic [3:0]        out_wr_wstrb,
   output logic [LINE_W-1:0] out_wr_data,
   input  logic              out_wr_rdy,
   output logic              out_rd_req,
   output logic [2:0]        out_rd_type,
   output logic [31:0]       out_rd_addr,
   input  logic              out_rd_rdy,
   output logic              empty
);

   localparam int               CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic                    push;
   logic                    pop;
   logic                    rd_hit;
   wb_entry_t               push_entry;
   wb_entry_t               head_entry;
   logic [CNT_W-1:0]        count;
   logic [DEPTH-1:0]        entry_valid;
   logic [DEPTH-1:0][31:0]  entry_addr;

   // Ready is decoded from the registered count only, never from a same-cycle pop.
   assign in_wr_rdy  = (count != FULL_CNT);
   assign out_wr_req = (count != '0);
   assign empty      = (count == '0);
   assign push       = in_wr_req & in_wr_rdy;
   assign pop        = out_wr_req & out_wr_rdy;

   always_comb begin
      push_entry.wr_type = wr_type_e'(in_wr_type);
      push_entry.addr    = in_wr_addr;
      push_entry.wstrb   = in_wr_wstrb;
      push_entry.data    = WB_LINE_W'(in_wr_data);
   end

   wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (pop),
      .head_entry  (head_entry),
      .count       (count),
      .entry_valid (entry_valid),
      .entry_addr  (entry_addr)
   );

   assign out_wr_type  = head_entry.wr_type;
   assign out_wr_addr  = head_entry.addr;
   assign out_wr_wstrb = head_entry.wstrb;
   assign out_wr_data  = LINE_W'(head_entry.data);

   // A write being accepted this cycle counts as pending, so the read cannot
   // overtake it on the bridge.
   always_comb begin
      rd_hit = push && same_line(in_wr_addr, in_rd_addr);
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && same_line(entry_addr[i], in_rd_addr)) rd_hit = 1'b1;
      end
   end

   assign out_rd_req  = in_rd_req & ~rd_hit & resetn;
   assign in_rd_rdy   = out_rd_rdy & ~rd_hit & resetn;
   assign out_rd_type = in_rd_type;
   assign out_rd_addr = in_rd_addr;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed self-checking bench for dcache_write_buffer (DEPTH=4, LINE_W=256).
module tb_dcache_write_buffer;
   import dcache_write_buffer_pkg::*;

   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_wr_req;
   logic [2:0]    in_wr_type;
   logic [31:0]   in_wr_addr;
   logic [3:0]    in_wr_wstrb;
   logic [LW-1:0] in_wr_data;
   logic          in_wr_rdy;
   logic          in_rd_req;
   logic [2:0]    in_rd_type;
   logic [31:0]   in_rd_addr;
   logic          in_rd_rdy;
   logic          out_wr_req;
   logic [2:0]    out_wr_type;
   logic [31:0]   out_wr_addr;
   logic [3:0]    out_wr_wstrb;
   logic [LW-1:0] out_wr_data;
   logic          out_wr_rdy;
   logic          out_rd_req;
   logic [2:0]    out_rd_type;
   logic [31:0]   out_rd_addr;
   logic          out_rd_rdy;
   logic          empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dcache_write_buffer #(.DEPTH(4), .LINE_W(LW)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_wr_req    (in_wr_req),
      .in_wr_type   (in_wr_type),
      .in_wr_addr   (in_wr_addr),
      .in_wr_wstrb  (in_wr_wstrb),
      .in_wr_data   (in_wr_data),
      .in_wr_rdy    (in_wr_rdy),
      .in_rd_req    (in_rd_req),
      .in_rd_type   (in_rd_type),
      .in_rd_addr   (in_rd_addr),
      .in_rd_rdy    (in_rd_rdy),
      .out_wr_req   (out_wr_req),
      .out_wr_type  (out_wr_type),
      .out_wr_addr  (out_wr_addr),
      .out_wr_wstrb (out_wr_wstrb),
      .out_wr_data  (out_wr_data),
      .out_wr_rdy   (out_wr_rdy),
      .out_rd_req   (out_rd_req),
      .out_rd_type  (out_rd_type),
      .out_rd_addr  (out_rd_addr),
      .out_rd_rdy   (out_rd_rdy),
      .empty        (empty)
   );

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LW-1:0] pattern(input logic [31:0] a);
      return {8{a}};
   endfunction

   task automatic drive_wr(input logic req, input logic [31:0] a, input logic [2:0] t,
                           input logic [3:0] s);
      in_wr_req   = req;
      in_wr_addr  = a;
      in_wr_type  = t;
      in_wr_wstrb = s;
      in_wr_data  = pattern(a);
   endtask

   logic [31:0] exp_q[$];
   logic [31:0] exp_a;
   int          n_sent;
   int          n_got;

   initial begin
      resetn     = 1'b0;
      drive_wr(1'b0, 32'h0, LINE, 4'h0);
      in_rd_req  = 1'b1;
      in_rd_type = LINE;
      in_rd_addr = 32'h0;
      out_wr_rdy = 1'b0;
      out_rd_rdy = 1'b1;
      #1;
      check("rst_empty", LW'(empty), LW'(1));
      check("rst_out_wr_req", LW'(out_wr_req), LW'(0));
      check("rst_in_wr_rdy", LW'(in_wr_rdy), LW'(1));
      check("rst_out_rd_req", LW'(out_rd_req), LW'(0));
      tick();
      tick();
      resetn    = 1'b1;
      in_rd_req = 1'b0;
      tick();

      // Fill with four LINE writes while the bridge stalls, then drain in order.
      for (int i = 0; i < 4; i++) begin
         drive_wr(1'b1, 32'h1000 + 32'(i) * 32'h20, LINE, 4'hF);
         #1;
         check("fill_in_wr_rdy", LW'(in_wr_rdy), LW'(1));
         tick();
      end
      in_wr_req = 1'b0;
      #1;
      check("full_in_wr_rdy", LW'(in_wr_rdy), LW'(0));
      check("full_empty", LW'(empty), LW'(0));
      check("full_out_wr_req", LW'(out_wr_req), LW'(1));
      out_wr_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_addr", LW'(out_wr_addr), LW'(32'h1000 + 32'(i) * 32'h20));
         check("drain_data", out_wr_data, pattern(32'h1000 + 32'(i) * 32'h20));
         check("drain_type", LW'(out_wr_type), LW'(3'b100));
         tick();
      end
      check("drain_empty", LW'(empty), LW'(1));
      check("drain_out_wr_req", LW'(out_wr_req), LW'(0));
      out_wr_rdy = 1'b0;

      // Read to a line pending in the buffer waits until the entry leaves.
      drive_wr(1'b1, 32'h2000, WORD, 4'hF);
      tick();
      in_wr_req  = 1'b0;
      in_rd_req  = 1'b1;
      in_rd_type = WORD;
      in_rd_addr = 32'h201C;
      #1;
      check("rhit_out_rd_req", LW'(out_rd_req), LW'(0));
      check("rhit_in_rd_rdy", LW'(in_rd_rdy), LW'(0));
      out_wr_rdy = 1'b1;
      #1;
      check("rhit_pop_cycle_blocked", LW'(out_rd_req), LW'(0));
      tick();
      out_wr_rdy = 1'b0;
      #1;
      check("rhit_after_out_rd_req", LW'(out_rd_req), LW'(1));
      check("rhit_after_in_rd_rdy", LW'(in_rd_rdy), LW'(1));
      check("rhit_after_addr", LW'(out_rd_addr), LW'(32'h201C));
      check("rhit_after_type", LW'(out_rd_type), LW'(3'b010));
      in_rd_req = 1'b0;

      // Same-cycle write and read to the same line blocks; another line passes.
      drive_wr(1'b1, 32'h3004, WORD, 4'hF);
      in_rd_req  = 1'b1;
      in_rd_addr = 32'h3010;
      #1;
      check("bypass_blocked_req", LW'(out_rd_req), LW'(0));
      check("bypass_blocked_rdy", LW'(in_rd_rdy), LW'(0));
      in_rd_addr = 32'h3020;
      #1;
      check("bypass_other_req", LW'(out_rd_req), LW'(1));
      check("bypass_other_rdy", LW'(in_rd_rdy), LW'(1));
      tick();
      in_wr_req = 1'b0;
      #1;
      check("bypass_entry_addr", LW'(out_wr_addr), LW'(32'h3004));
      check("bypass_entry_wstrb", LW'(out_wr_wstrb), LW'(4'hF));
      check("bypass_entry_type", LW'(out_wr_type), LW'(3'b010));
      check("bypass_other_still_fwd", LW'(out_rd_req), LW'(1));
      in_rd_req  = 1'b0;
      out_wr_rdy = 1'b1;
      tick();
      out_wr_rdy = 1'b0;
      check("bypass_drained", LW'(empty), LW'(1));

      // Full buffer with a pop pending: the push waits one cycle.
      for (int i = 0; i < 4; i++) begin
         drive_wr(1'b1, 32'h4000 + 32'(i) * 32'h20, LINE, 4'hF);
         tick();
      end
      drive_wr(1'b1, 32'h4080, LINE, 4'hF);
      out_wr_rdy = 1'b1;
      #1;
      check("fullpop_in_wr_rdy", LW'(in_wr_rdy), LW'(0));
      tick();
      check("fullpop_head", LW'(out_wr_addr), LW'(32'h4020));
      check("fullpop_rdy_next", LW'(in_wr_rdy), LW'(1));
      tick();
      in_wr_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("fullpop_order", LW'(out_wr_addr), LW'(32'h4040 + 32'(i) * 32'h20));
         tick();
      end
      check("fullpop_empty", LW'(empty), LW'(1));

      // Streaming push/pop across pointer wrap, checked against a scoreboard.
      n_sent = 0;
      n_got  = 0;
      for (int cyc = 0; cyc < 30 && (n_sent < 20 || n_got < 20); cyc++) begin
         drive_wr(n_sent < 20, 32'h5000 + 32'(n_sent) * 32'h20, LINE, 4'hF);
         #1;
         if (out_wr_req && out_wr_rdy) begin
            if (exp_q.size() == 0) begin
               check("stream_spurious_pop", LW'(out_wr_req), LW'(0));
            end else begin
               exp_a = exp_q.pop_front();
               check("stream_addr", LW'(out_wr_addr), LW'(exp_a));
               check("stream_data", out_wr_data, pattern(exp_a));
            end
            n_got++;
         end
         if (in_wr_req && in_wr_rdy) begin
            exp_q.push_back(in_wr_addr);
            n_sent++;
         end
         tick();
      end
      in_wr_req = 1'b0;
      check("stream_sent", LW'(n_sent), LW'(20));
      check("stream_got", LW'(n_got), LW'(20));
      check("stream_empty", LW'(empty), LW'(1));
      out_wr_rdy = 1'b0;

      // Reset mid-stream discards pending entries without waiting for a clock.
      for (int i = 0; i < 3; i++) begin
         drive_wr(1'b1, 32'h6000 + 32'(i) * 32'h20, LINE, 4'hF);
         tick();
      end
      in_wr_req = 1'b0;
      #1;
      check("pre_rst_empty", LW'(empty), LW'(0));
      check("pre_rst_out_wr_req", LW'(out_wr_req), LW'(1));
      resetn = 1'b0;
      #1;
      check("async_rst_empty", LW'(empty), LW'(1));
      check("async_rst_out_wr_req", LW'(out_wr_req), LW'(0));
      check("async_rst_in_wr_rdy", LW'(in_wr_rdy), LW'(1));
      tick();
      resetn     = 1'b1;
      in_rd_req  = 1'b1;
      in_rd_addr = 32'h6000;
      tick();
      check("post_rst_empty", LW'(empty), LW'(1));
      check("post_rst_read_fwd", LW'(out_rd_req), LW'(1));
      in_rd_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_write_buffer.md
DCACHE_WRITE_BUFFER -- requirements
Module: dcache_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered write entries; power of two, at least 2.
REQ-002 SHALL have parameter LINE_W, default 256: width of the write data bus, equal to the shared line width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 in_wr_req / in_wr_type / in_wr_addr / in_wr_wstrb / in_wr_data  in  1/3/32/4/LINE_W  write request from dcache.
REQ-006 in_wr_rdy  out  1  buffer can accept a write this cycle.
REQ-007 in_rd_req / in_rd_type / in_rd_addr  in  1/3/32  read request from dcache.
REQ-008 in_rd_rdy  out  1  read accepted by the bridge this cycle.
REQ-009 out_wr_req / out_wr_type / out_wr_addr / out_wr_wstrb / out_wr_data  out  1/3/32/4/LINE_W  head-entry write to axi_bridge.
REQ-010 out_wr_rdy  in  1  bridge accepts the write.
REQ-011 out_rd_req / out_rd_type / out_rd_addr  out  1/3/32  read forwarded to axi_bridge.
REQ-012 out_rd_rdy  in  1  bridge accepts the read.
REQ-013 empty  out  1  no valid entries are held.

Function
REQ-014 A write handshake SHALL occur when req and rdy are both high in the same cycle; the buffer SHALL NOT drop or duplicate any request.
REQ-015 in_wr_rdy SHALL equal (count != DEPTH), decoded from registered state; a pop in the same cycle SHALL NOT make a full buffer ready.
REQ-016 An accepted input write SHALL be stored at tail and appear on out_wr_* no earlier than the next cycle; there SHALL be no combinational bypass.
REQ-017 out_wr_req SHALL equal (count != 0); out_wr_* fields SHALL be the head entry, held stable until popped.
REQ-018 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged; both pointers advance.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits and never exceed DEPTH.
REQ-020 Writes SHALL leave in acceptance order.
REQ-021 An entry hits a read when its valid bit is set and addr[31:5] equals in_rd_addr[31:5], for all wr_type values including uncached byte/half/word.
REQ-022 A read SHALL also hit when in_wr_req & in_wr_rdy is high with an equal in_wr_addr[31:5] in the same cycle.
REQ-023 On a read hit, out_rd_req SHALL be 0 and in_rd_rdy SHALL be 0, until no hit remains.
REQ-024 Without a hit, out_rd_* SHALL equal in_rd_* and in_rd_rdy SHALL equal out_rd_rdy, combinationally.
REQ-025 empty SHALL equal (count == 0) from registered state.

Reset
REQ-026 While resetn is low: count=0, pointers=0, all valid bits=0.
REQ-027 While resetn is low: out_wr_req=0, empty=1, in_wr_rdy=1, out_rd_req=0.
REQ-028 Assertion of reset mid-transfer SHALL discard all entries.
REQ-029 Entry data storage needs no reset.

Structure
REQ-030 The shared package SHALL hold the wr_type encodings BYTE=3'b000, HALF=3'b001, WORD=3'b010, LINE=3'b100, the line-width constant, and struct wb_entry_t {type, addr, wstrb, data}.
REQ-031 Storage plus pointers SHALL be one sub-module, wb_fifo; the address-hit compare and read gating SHALL stay in the top module.

Verification
REQ-032 Push four LINE writes 0x1000, 0x1020, 0x1040, 0x1060 with out_wr_rdy=0 -> in_wr_rdy=0 after the fourth and empty=0; then out_wr_rdy=1 -> pops in that order, empty=1 four cycles later.
REQ-033 Hold one entry at 0x2000; in_rd_req at 0x201C -> out_rd_req=0, in_rd_rdy=0; pop the entry -> the read forwards the next cycle.
REQ-034 Same cycle: in_wr_req at 0x3004 (WORD, wstrb 4'hF) and in_rd_req at 0x3010 -> read blocked; in_rd_req at 0x3020 -> forwarded.
REQ-035 Full buffer with out_wr_rdy=1 and in_wr_req=1 -> no push that cycle; push accepted the next cycle; ordering preserved.
REQ-036 Continuous push/pop for 20 cycles with DEPTH=4 -> pointers wrap, no loss, and the output address sequence matches the input sequence.
REQ-037 Drop resetn with 3 entries pending -> empty=1 and out_wr_req=0 immediately, asynchronously.
